ghost_mover: RTL and testbench

GHOST_MOVER -- requirements
Module: ghost_mover

---
 rtl/ghost_pkg.sv | 30 +++
 rtl/ghost_mover_tick_gen.sv | 33 +++
 rtl/ghost_mover.sv | 134 +++++++++++++
 tb/tb_ghost_mover.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and screen geometry for the ghost sprite logic.
package ghost_pkg;

  // Ghost behaviour states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHASE  = 2'd1,
    HOLD   = 2'd2,
    CAUGHT = 2'd3
  } state_t;

  // Direction of the most recent step actually taken.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  // Visible screen size in pixels.
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  // Legal ghost centre range: keeps the 3x3 sprite fully on screen.
  localparam logic [9:0] X_MIN = 10'd1;
  localparam logic [9:0] X_MAX = 10'(SCR_W - 2);
  localparam logic [8:0] Y_MIN = 9'd1;
  localparam logic [8:0] Y_MAX = 9'(SCR_H - 2);

endpackage

// File: rtl/ghost_mover_tick_gen.sv
// Move-step divider: counts 0..TICK_DIV-1 while enabled and flags the last
// count with a single-cycle tick. Holding enable low freezes the count.
module move_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Divider counter: clear wins, otherwise wrap-count only when enabled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/ghost_mover.sv
// Ghost chaser: a four-state FSM plus a one-pixel-per-tick position
// datapath that walks the ghost toward pacman along the dominant axis.
module ghost_mover
  import ghost_pkg::*;
#(
  parameter int X_START  = 320,
  parameter int Y_START  = 240,
  parameter int TICK_DIV = 833333,
  parameter int CATCH_R  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_start,
  input  logic       m_hold,
  input  logic [9:0] xPac,
  input  logic [8:0] yPac,
  output logic [9:0] xGhost,
  output logic [8:0] yGhost,
  output logic [1:0] dir,
  output logic       caught
);

  state_t state, state_nxt;
  dir_t   dir_q, dir_nxt;
  logic [9:0] x_nxt;
  logic [8:0] y_nxt;

  logic signed [10:0] dx;
  logic signed [9:0]  dy;
  logic [10:0] adx;
  logic [9:0]  ady;
  logic near;
  logic tick;

  // Signed offsets one bit wider than the coordinates, and their magnitudes.
  assign dx  = signed'({1'b0, xPac}) - signed'({1'b0, xGhost});
  assign dy  = signed'({1'b0, yPac}) - signed'({1'b0, yGhost});
  assign adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[9]  ? $unsigned(-dy) : $unsigned(dy);
  assign near = (adx <= 11'(CATCH_R)) && (ady <= 10'(CATCH_R));

  // Step timing runs only while chasing; pausing freezes it mid-count and
  // leaving the chase (idle/caught) discards any partial count.
  move_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .enable (state == CHASE),
    .clear  ((state == IDLE) || (state == CAUGHT)),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a catch takes priority over a pause request.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (e_start) state_nxt = CHASE;
      CHASE: begin
        if (near)        state_nxt = CAUGHT;
        else if (m_hold) state_nxt = HOLD;
      end
      HOLD:    if (!m_hold) state_nxt = CHASE;
      CAUGHT:  if (e_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step selection: dominant axis (x on a tie), one pixel toward pacman,
  // suppressed at the screen bounds; direction follows only real steps.
  always_comb begin
    x_nxt   = xGhost;
    y_nxt   = yGhost;
    dir_nxt = dir_q;
    if ((state == CHASE) && tick && !near) begin
      if ((adx >= {1'b0, ady}) && (adx != '0)) begin
        if (!dx[10]) begin
          if (xGhost < X_MAX) begin
            x_nxt   = xGhost + 10'd1;
            dir_nxt = RIGHT;
          end
        end else begin
          if (xGhost > X_MIN) begin
            x_nxt   = xGhost - 10'd1;
            dir_nxt = LEFT;
          end
        end
      end else if (ady != '0) begin
        if (!dy[9]) begin
          if (yGhost < Y_MAX) begin
            y_nxt   = yGhost + 9'd1;
            dir_nxt = DOWN;
          end
        end else begin
          if (yGhost > Y_MIN) begin
            y_nxt   = yGhost - 9'd1;
            dir_nxt = UP;
          end
        end
      end
    end
  end

  // Position and direction registers; restart from CAUGHT reloads home.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xGhost <= 10'(X_START);
      yGhost <= 9'(Y_START);
      dir_q  <= LEFT;
    end else if ((state == CAUGHT) && e_start) begin
      xGhost <= 10'(X_START);
      yGhost <= 9'(Y_START);
    end else begin
      xGhost <= x_nxt;
      yGhost <= y_nxt;
      dir_q  <= dir_nxt;
    end
  end

  assign dir    = dir_q;
  assign caught = (state == CAUGHT);

endmodule

// File: tb/tb_ghost_mover.sv
// Self-checking bench for ghost_mover with a fast divider (TICK_DIV=4).
module tb_ghost_mover;
  import ghost_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       e_start;
  logic       m_hold;
  logic [9:0] xPac;
  logic [8:0] yPac;
  logic [9:0] xGhost;
  logic [8:0] yGhost;
  logic [1:0] dir;
  logic       caught;

  int n_checks = 0;
  int n_errors = 0;

  localparam int DU = int'(UP);
  localparam int DD = int'(DOWN);
  localparam int DL = int'(LEFT);
  localparam int DR = int'(RIGHT);

  typedef struct {
    string      tag;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] d;
    logic       c;
  } exp_t;

  exp_t sb[$];

  ghost_mover #(
    .X_START  (320),
    .Y_START  (240),
    .TICK_DIV (4),
    .CATCH_R  (2)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .e_start (e_start),
    .m_hold  (m_hold),
    .xPac    (xPac),
    .yPac    (yPac),
    .xGhost  (xGhost),
    .yGhost  (yGhost),
    .dir     (dir),
    .caught  (caught)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input int x, input int y, input int d, input int c);
    exp_t e;
    e.tag = tag;
    e.x   = 10'(x);
    e.y   = 9'(y);
    e.d   = 2'(d);
    e.c   = 1'(c);
    sb.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".x"},      xGhost, e.x);
      check({e.tag, ".y"},      yGhost, e.y);
      check({e.tag, ".dir"},    dir,    e.d);
      check({e.tag, ".caught"}, caught, e.c);
    end
  endtask

  // Queue an expectation, run n cycles, then compare against the DUT.
  task automatic expect_after(input int n, input string tag, input int x, input int y,
                              input int d, input int c);
    sb_push(tag, x, y, d, c);
    tick(n);
    sb_compare();
  endtask

  task automatic pulse_start();
    e_start = 1'b1;
    tick(1);
    e_start = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    e_start = 1'b0;
    m_hold  = 1'b0;
    xPac    = 10'd330;
    yPac    = 9'd240;

    // Reset values, then 100 idle cycles with no start request.
    #12;
    sb_push("rst", 320, 240, DL, 0);
    sb_compare();
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) expect_after(25, "idle", 320, 240, DL, 0);

    // Straight chase to the right until caught at x=328.
    pulse_start();
    expect_after(3, "chase_pre", 320, 240, DL, 0);
    expect_after(1, "chase_s1", 321, 240, DR, 0);
    for (int k = 2; k <= 8; k++) expect_after(4, "chase_s", 320 + k, 240, DR, 0);
    expect_after(1, "catch", 328, 240, DR, 1);
    expect_after(12, "caught_frz", 328, 240, DR, 1);

    // Restart from CAUGHT: reload home, stay idle, then resume chasing.
    e_start = 1'b1;
    expect_after(1, "reload", 320, 240, DR, 0);
    e_start = 1'b0;
    expect_after(6, "idle_wait", 320, 240, DR, 0);
    pulse_start();
    expect_after(4, "resume", 321, 240, DR, 0);

    // Pause after two counts; start requests are ignored while paused.
    tick(2);
    m_hold  = 1'b1;
    e_start = 1'b1;
    for (int i = 0; i < 4; i++) expect_after(5, "hold", 321, 240, DR, 0);
    e_start = 1'b0;
    m_hold  = 1'b0;
    expect_after(1, "unhold1", 321, 240, DR, 0);
    expect_after(1, "unhold2", 322, 240, DR, 0);

    // Reset on the cycle a step is due: no step, async return to home.
    tick(3);
    rst_n = 1'b0;
    #2;
    sb_push("rst_async", 320, 240, DL, 0);
    sb_compare();
    expect_after(1, "rst_hold", 320, 240, DL, 0);
    rst_n = 1'b1;
    expect_after(12, "post_rst", 320, 240, DL, 0);

    // Axis selection: tie goes to x, otherwise the larger offset wins.
    xPac = 10'd325;
    yPac = 9'd245;
    pulse_start();
    expect_after(4, "tie_x", 321, 240, DR, 0);
    expect_after(4, "y_big", 321, 241, DD, 0);
    expect_after(4, "tie_x2", 322, 241, DR, 0);
    expect_after(4, "y_big2", 322, 242, DD, 0);
    expect_after(4, "tie_x3", 323, 242, DR, 0);
    expect_after(4, "y_big3", 323, 243, DD, 0);
    expect_after(1, "catch2", 323, 243, DD, 1);

    // Right screen bound: walk to x=638 and stop there.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    xPac = 10'd1000;
    yPac = 9'd240;
    pulse_start();
    expect_after(4 * 318, "xmax", 638, 240, DR, 0);
    expect_after(40, "xmax_hold", 638, 240, DR, 0);

    // Bottom screen bound: walk to y=478 and stop there.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    xPac = 10'd320;
    yPac = 9'd511;
    pulse_start();
    expect_after(4 * 238, "ymax", 320, 478, DD, 0);
    expect_after(40, "ymax_hold", 320, 478, DD, 0);

    // Upward moves with pacman directly above.
    yPac = 9'd400;
    expect_after(4, "up1", 320, 477, DU, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
